// File: rtl/ex_alu_multicycle_if.sv
// Handshake bundle between decode, the execute unit and writeback.
// master = decode/writeback side, slave = execute unit.
interface ex_alu_multicycle_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  // Decode -> execute
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] alu_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            alu_src1;
  logic            alu_src2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  // Execute -> writeback
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [OP_W-1:0] op_o;
  logic            illegal;

  modport master (
    output in_valid, alu_op, rs1_data, rs2_data, alu_src1, alu_src2, imm, pc,
    output out_ready,
    input  in_ready, out_valid, result, op_o, illegal
  );

  modport slave (
    input  in_valid, alu_op, rs1_data, rs2_data, alu_src1, alu_src2, imm, pc,
    input  out_ready,
    output in_ready, out_valid, result, op_o, illegal
  );
endinterface

// File: rtl/ex_alu_multicycle.sv
// Multi-cycle execute unit: single-cycle ALU ops plus an iterative
// radix-2 multiplier and restoring divider sharing one accumulator pair.
// IDLE accepts an op; ALU/illegal ops go straight to DONE, mul/div spend
// XLEN cycles in CALC. DONE holds the result until writeback takes it.
module ex_alu_multicycle #(
  parameter int XLEN   = 32,
  parameter int OP_W   = 5,
  parameter bit MDU_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ex_alu_multicycle_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD0  = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OP_ADD1  = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_ADD2  = OP_W'(5'b10100);
  localparam logic [OP_W-1:0] OP_ADD3  = OP_W'(5'b10101);
  localparam logic [OP_W-1:0] OP_ADD4  = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_ADD5  = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] OP_MULH  = OP_W'(5'b11001);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(5'b11100);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(5'b11101);
  localparam logic [OP_W-1:0] OP_REM   = OP_W'(5'b11110);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(5'b11111);

  localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2 = (2*XLEN)'(1);
  localparam logic [SHW-1:0]    LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD3, OP_ADD4, OP_ADD5,
      OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SRL, OP_SLL, OP_SRA,
      OP_SLT, OP_SLTU: is_alu_op = 1'b1;
      default:         is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_mdu_op = 1'b1;
      default:                          is_mdu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div_op = 1'b1;
      default:                          is_div_op = 1'b0;
    endcase
  endfunction

  // Ops whose operands are taken as two's-complement magnitudes
  function automatic logic is_signed_mdu(input logic [OP_W-1:0] op);
    is_signed_mdu = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic neg,
                                                input logic [XLEN-1:0] v);
    negate_if = neg ? (~v + ONE) : v;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(input logic [OP_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         shamt;
    a_s   = a;
    b_s   = b;
    shamt = b[SHW-1:0];
    case (op)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD3, OP_ADD4, OP_ADD5:
                alu_eval = a + b;
      OP_SUB:   alu_eval = a - b;
      OP_XOR:   alu_eval = a ^ b;
      OP_OR:    alu_eval = a | b;
      OP_AND:   alu_eval = a & b;
      OP_SRL:   alu_eval = a >> shamt;
      OP_SLL:   alu_eval = a << shamt;
      OP_SRA:   alu_eval = a_s >>> shamt;
      OP_SLT:   alu_eval = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:  alu_eval = {{(XLEN-1){1'b0}}, (a < b)};
      default:  alu_eval = '0;
    endcase
  endfunction

  // Control state (reset) and architectural outputs (reset to 0)
  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;

  // Iteration datapath (no reset; always loaded on accept)
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dbz_q, dbz_d;

  logic [XLEN-1:0]   opa, opb;
  logic              sgn_a, sgn_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [XLEN:0]     div_rs;
  logic [XLEN+1:0]   div_diff;
  logic              div_borrow;
  logic [XLEN-1:0]   div_hi, div_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   fin_res;

  // Operand muxing and sign extraction for the accept cycle
  always_comb begin
    opa   = bus.alu_src1 ? bus.pc  : bus.rs1_data;
    opb   = bus.alu_src2 ? bus.imm : bus.rs2_data;
    sgn_a = opa[XLEN-1] & is_signed_mdu(bus.alu_op);
    sgn_b = opb[XLEN-1] & is_signed_mdu(bus.alu_op);
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi     = mul_sum[XLEN:1];
    mul_lo     = {mul_sum[0], lo_q[XLEN-1:1]};
    div_rs     = {hi_q, lo_q[XLEN-1]};
    div_diff   = {1'b0, div_rs} - {2'b00, opb_q};
    div_borrow = div_diff[XLEN+1];
    div_hi     = div_borrow ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0];
    div_lo     = {lo_q[XLEN-2:0], ~div_borrow};
  end

  // Sign fix-up and result selection applied on the final iteration
  always_comb begin
    prod     = {mul_hi, mul_lo};
    prod_fix = neg_quo_q ? (~prod + ONE2) : prod;
    case (op_q)
      OP_MUL:   fin_res = mul_lo;
      OP_MULH:  fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_MULHU: fin_res = mul_hi;
      // A zero divisor yields all-ones regardless of the dividend sign
      OP_DIV:   fin_res = dbz_q ? '1 : negate_if(neg_quo_q, div_lo);
      OP_DIVU:  fin_res = div_lo;
      OP_REM:   fin_res = negate_if(neg_rem_q, div_hi);
      OP_REMU:  fin_res = div_hi;
      default:  fin_res = '0;
    endcase
  end

  // Next-state, iteration and result update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.alu_op;
          if (MDU_EN && is_mdu_op(bus.alu_op)) begin
            hi_d      = '0;
            lo_d      = negate_if(sgn_a, opa);
            opb_d     = negate_if(sgn_b, opb);
            neg_quo_d = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a;
            dbz_d     = (opb == '0);
            cnt_d     = '0;
            state_d   = S_CALC;
          end else if (is_alu_op(bus.alu_op)) begin
            result_d  = alu_eval(bus.alu_op, opa, opb);
            illegal_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_CALC: begin
        hi_d  = is_div_op(op_q) ? div_hi : mul_hi;
        lo_d  = is_div_op(op_q) ? div_lo : mul_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result_d  = fin_res;
          illegal_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Iteration datapath registers
  always_ff @(posedge clk) begin
    hi_q      <= hi_d;
    lo_q      <= lo_d;
    opb_q     <= opb_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dbz_q     <= dbz_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.op_o      = op_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_ex_alu_multicycle.sv
// Randomised and directed bench for ex_alu_multicycle against an
// arithmetic reference model; a second instance has the MDU disabled.
module tb_ex_alu_multicycle;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ex_alu_multicycle_if #(.XLEN(32), .OP_W(5)) bus ();
  ex_alu_multicycle_if #(.XLEN(32), .OP_W(5)) bus_nm ();

  ex_alu_multicycle #(.XLEN(32), .OP_W(5), .MDU_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ex_alu_multicycle #(.XLEN(32), .OP_W(5), .MDU_EN(1'b0)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result, illegal flag and cycles from accept to out_valid
  function automatic void ref_model(input logic [4:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill,
                                    output int lat);
    int          sa, sb;
    longint      sprod;
    logic [63:0] uprod;
    logic [63:0] sprod_bits;
    sa = a;
    sb = b;
    sprod = longint'(sa) * longint'(sb);
    sprod_bits = sprod;
    uprod = {32'd0, a} * {32'd0, b};
    ill = 1'b0;
    lat = 1;
    r   = 32'd0;
    case (op)
      5'b10001, 5'b10010, 5'b10100, 5'b10101, 5'b01100, 5'b01101: r = a + b;
      5'b01110: r = a - b;
      5'b00110: r = a ^ b;
      5'b00101: r = a | b;
      5'b00100: r = a & b;
      5'b01001: r = a >> (b % 32);
      5'b01000: r = a << (b % 32);
      5'b01010: r = 32'(sa >>> (b % 32));
      5'b00111: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b11000: begin lat = 33; r = uprod[31:0]; end
      5'b11001: begin lat = 33; r = sprod_bits[63:32]; end
      5'b11010: begin lat = 33; r = uprod[63:32]; end
      5'b11100: begin
        lat = 33;
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(sa / sb);
      end
      5'b11101: begin lat = 33; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
      5'b11110: begin
        lat = 33;
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(sa % sb);
      end
      5'b11111: begin lat = 33; r = (b == 0) ? a : a % b; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       pick_val = 32'd0;
      1:       pick_val = 32'd1;
      2:       pick_val = 32'hFFFF_FFFF;
      3:       pick_val = 32'h8000_0000;
      4:       pick_val = 32'h7FFF_FFFF;
      default: pick_val = $urandom;
    endcase
  endfunction

  // Issue one op, check latency and outputs, hold DONE, then retire it
  task automatic run_op(input logic [4:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im,
                        input logic [31:0] p, input logic s1, input logic s2,
                        input int hold, output logic [31:0] got);
    logic [31:0] a, b, exp_r;
    logic        exp_ill;
    int          exp_lat, cyc;
    a = s1 ? p : r1;
    b = s2 ? im : r2;
    ref_model(op, a, b, exp_r, exp_ill, exp_lat);
    check_eq("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.imm       = im;
    bus.pc        = p;
    bus.alu_src1  = s1;
    bus.alu_src2  = s2;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.alu_op   = 5'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.imm      = $urandom;
    bus.pc       = $urandom;
    bus.alu_src1 = 1'($urandom);
    bus.alu_src2 = 1'($urandom);
    cyc = 1;
    while (!bus.out_valid && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", cyc, exp_lat);
    check_eq("result", bus.result, exp_r);
    check_eq("illegal", bus.illegal, exp_ill);
    check_eq("op_o", bus.op_o, op);
    got = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_result", bus.result, exp_r);
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("post_valid", bus.out_valid, 0);
    check_eq("post_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [4:0]  rop;
    n_checks = 0;
    n_fail   = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_op = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0; bus.pc = '0;
    bus.alu_src1 = 1'b0; bus.alu_src2 = 1'b0;
    bus_nm.in_valid = 1'b0; bus_nm.out_ready = 1'b0; bus_nm.alu_op = '0;
    bus_nm.rs1_data = '0; bus_nm.rs2_data = '0; bus_nm.imm = '0;
    bus_nm.pc = '0; bus_nm.alu_src1 = 1'b0; bus_nm.alu_src2 = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_op_o", bus.op_o, 0);
    check_eq("rst_illegal", bus.illegal, 0);
    rst = 1'b0;

    // Directed cases with known answers
    run_op(5'b10001, 32'd5, 32'd99, 32'd7, 32'd0, 1'b0, 1'b1, 0, got);
    check_eq("add_5_7", got, 32'd12);
    run_op(5'b01110, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("sub_0_1", got, 32'hFFFF_FFFF);
    run_op(5'b01010, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("sra", got, 32'hF800_0000);
    run_op(5'b00011, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("sltu", got, 32'd1);
    run_op(5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("slt", got, 32'd1);
    run_op(5'b01100, 32'd0, 32'd0, 32'h10, 32'h1000, 1'b1, 1'b1, 0, got);
    check_eq("add_pc_imm", got, 32'h1010);
    run_op(5'b11000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("mul", got, 32'd1);
    run_op(5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("mulh", got, 32'd0);
    run_op(5'b11010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("mulhu", got, 32'hFFFF_FFFE);
    run_op(5'b11100, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("div_m7_2", got, 32'hFFFF_FFFD);
    run_op(5'b11110, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("rem_m7_2", got, 32'hFFFF_FFFF);
    run_op(5'b11101, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("divu_by0", got, 32'hFFFF_FFFF);
    run_op(5'b11111, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("remu_by0", got, 32'd9);
    run_op(5'b11100, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("div_neg_by0", got, 32'hFFFF_FFFF);
    run_op(5'b11100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("div_ovf", got, 32'h8000_0000);
    run_op(5'b11110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, got);
    check_eq("rem_ovf", got, 32'd0);
    run_op(5'b00110, 32'hA5A5_0000, 32'h0F0F_0F0F, 32'd0, 32'd0, 1'b0, 1'b0, 5, got);
    check_eq("xor_hold", got, 32'hAAAA_0F0F);
    run_op(5'b00000, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1, got);
    check_eq("illegal_res", got, 32'd0);

    // Reset in the middle of a divide discards it
    bus.in_valid = 1'b1; bus.alu_op = 5'b11101;
    bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7;
    bus.alu_src1 = 1'b0; bus.alu_src2 = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("calc_in_ready", bus.in_ready, 0);
    check_eq("calc_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    check_eq("midrst_op_o", bus.op_o, 0);
    repeat (40) @(negedge clk);
    check_eq("midrst_no_done", bus.out_valid, 0);

    // MDU disabled: remu is illegal and completes in one cycle
    bus_nm.in_valid = 1'b1; bus_nm.alu_op = 5'b11111;
    bus_nm.rs1_data = 32'd9; bus_nm.rs2_data = 32'd2;
    @(negedge clk);
    bus_nm.in_valid = 1'b0;
    check_eq("nomdu_valid", bus_nm.out_valid, 1);
    check_eq("nomdu_illegal", bus_nm.illegal, 1);
    check_eq("nomdu_result", bus_nm.result, 0);
    bus_nm.out_ready = 1'b1;
    @(negedge clk);
    bus_nm.out_ready = 1'b0;
    check_eq("nomdu_retire", bus_nm.in_ready, 1);

    // Random ops against the reference model
    for (int n = 0; n < 160; n++) begin
      rop = 5'($urandom);
      run_op(rop, pick_val(), pick_val(), pick_val(), pick_val(),
             1'($urandom), 1'($urandom), $urandom_range(0, 2), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
